// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
//
// Purpose
//   Shared definitions for the interval-timer control stage: the FSM state
//   encoding, the counter direction constant and a small state helper.
//
// Contents
//   timer_state_t  T_IDLE / T_LOAD / T_RUN
//   CNT_DOWN       direction value driven onto the counter's up/down pin
//   is_busy()      1 when the timer FSM is anywhere other than T_IDLE
// ---------------------------------------------------------------------------
package timer_pkg;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_LOAD = 2'd1,
        T_RUN  = 2'd2
    } timer_state_t;

    // The attached counter counts down when its direction pin is low.
    localparam logic CNT_DOWN = 1'b0;

    function automatic logic is_busy(input timer_state_t s);
        return (s != T_IDLE);
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// ---------------------------------------------------------------------------
// prescaler
//
// Purpose
//   Divides the clock by (div + 1). While enabled, an internal count runs
//   0, 1, ..., div, 0, ... and strobe is high in the cycle where the count
//   equals div. The equality compare means the count can never run past
//   div, so no overflow handling is needed for any div value.
//
// Ports
//   clk     in   1   clock, all logic on posedge
//   rst_n   in   1   asynchronous active-low reset, clears the count
//   clr     in   1   synchronous clear; wins over en
//   en      in   1   advance the count this cycle
//   div     in   PW  divisor minus one
//   strobe  out  1   combinational: en & (count == div)
// ---------------------------------------------------------------------------
module prescaler #(
    parameter int PW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic [PW-1:0] div,
    output logic          strobe
);

    logic [PW-1:0] count_reg;
    logic          at_div;

    assign at_div = (count_reg == div);
    assign strobe = en && at_div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            // Wrap on the strobe cycle so the next strobe is div+1 cycles later.
            if (at_div) begin
                count_reg <= '0;
            end else begin
                count_reg <= count_reg + PW'(1);
            end
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// ---------------------------------------------------------------------------
// timer_ctrl
//
// Purpose
//   Control stage for an N-bit up/down counter, forming a programmable
//   one-shot / periodic interval timer. On an accepted start the period,
//   prescale divisor and mode are latched; the counter is then loaded with
//   the period and stepped down once every (presc+1) clocks. When the counter
//   reports its final 1->0 step (cnt_tic during an enabled cycle) a one-cycle
//   expired pulse is produced on the following cycle and the timer either
//   reloads (periodic) or returns to idle (one-shot).
//
// Ports
//   clk       in   1   clock, all logic on posedge
//   rst_n     in   1   asynchronous active-low reset
//   start     in   1   pulse: arm the timer (ignored while busy or period==0)
//   stop      in   1   pulse: abort and return to idle; beats start and expiry
//   periodic  in   1   1 = auto-reload on expiry; sampled on accepted start
//   period    in   N   terminal count P; sampled on accepted start
//   presc     in   PW  prescale divisor minus one D; sampled on accepted start
//   cnt_tic   in   1   counter strobe for the enabled 1->0 step
//   cnt_en    out  1   counter enable
//   cnt_load  out  1   counter synchronous load
//   cnt_data  out  N   counter load value (latched period)
//   cnt_updn  out  1   counter direction, constant down
//   busy      out  1   timer is loading or running
//   expired   out  1   registered one-cycle expiry pulse
//
// Timing
//   One-shot: expired is high P*(D+1)+2 cycles after the start cycle.
//   Periodic: expired pulses repeat every P*(D+1)+1 cycles; each expired
//   cycle coincides with the reload cycle of the next interval.
// ---------------------------------------------------------------------------
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int N  = 8,
    parameter int PW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic          periodic,
    input  logic [N-1:0]  period,
    input  logic [PW-1:0] presc,
    input  logic          cnt_tic,
    output logic          cnt_en,
    output logic          cnt_load,
    output logic [N-1:0]  cnt_data,
    output logic          cnt_updn,
    output logic          busy,
    output logic          expired
);

    timer_state_t  state_reg;
    timer_state_t  state_next;

    logic [N-1:0]  period_reg;
    logic [PW-1:0] presc_reg;
    logic          periodic_reg;
    logic          expired_reg;
    logic          expired_next;
    logic          latch_next;

    logic          pre_clr;
    logic          pre_en;
    logic          strobe;

    // -----------------------------------------------------------------------
    // Prescaler: cleared during the load cycle so every interval starts with
    // a full D+1 cycle wait before the first counter step.
    // Its controls are decoded straight from the state register (not from the
    // next-state block) so strobe never feeds back into its own enable.
    // -----------------------------------------------------------------------
    assign pre_clr = (state_reg == T_LOAD);
    assign pre_en  = (state_reg == T_RUN);

    prescaler #(
        .PW (PW)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (pre_clr),
        .en     (pre_en),
        .div    (presc_reg),
        .strobe (strobe)
    );

    // -----------------------------------------------------------------------
    // State register, input latches and registered expiry pulse
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= T_IDLE;
            period_reg   <= '0;
            presc_reg    <= '0;
            periodic_reg <= 1'b0;
            expired_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            expired_reg <= expired_next;
            // Latches only move on an accepted start, so they stay stable for
            // the whole run and survive a stop.
            if (latch_next) begin
                period_reg   <= period;
                presc_reg    <= presc;
                periodic_reg <= periodic;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and counter-control decode
    // -----------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        latch_next   = 1'b0;
        expired_next = 1'b0;
        cnt_en       = 1'b0;
        cnt_load     = 1'b0;

        case (state_reg)
            T_IDLE: begin
                // A zero period would never produce a tic, so it is refused.
                if (start && (period != '0)) begin
                    latch_next = 1'b1;
                    state_next = T_LOAD;
                end
            end

            T_LOAD: begin
                cnt_en     = 1'b1;
                cnt_load   = 1'b1;
                state_next = T_RUN;
            end

            T_RUN: begin
                cnt_en = strobe;
                // cnt_tic only counts in a cycle where the counter was enabled.
                if (strobe && cnt_tic) begin
                    expired_next = 1'b1;
                    state_next   = periodic_reg ? T_LOAD : T_IDLE;
                end
            end

            default: begin
                state_next = T_IDLE;
            end
        endcase

        // stop overrides everything decided above, including a final tic.
        if (stop) begin
            state_next   = T_IDLE;
            latch_next   = 1'b0;
            expired_next = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign cnt_data = period_reg;
    assign cnt_updn = CNT_DOWN;
    assign busy     = is_busy(state_reg);
    assign expired  = expired_reg;

endmodule

// File: tb/tb_timer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_timer_ctrl
//
// Bench for timer_ctrl with a behavioural N-bit down-counter attached to the
// cnt_* pins. A reference model computes expected outputs for every cycle
// from interval arithmetic (load cycle, interval length P*(D+1)+1, step
// positions at multiples of D+1), independent of any state encoding.
// ---------------------------------------------------------------------------
module tb_timer_ctrl;

    localparam int N  = 8;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          periodic = 1'b0;
    logic [N-1:0]  period = '0;
    logic [PW-1:0] presc = '0;
    logic          cnt_tic;
    logic          cnt_en;
    logic          cnt_load;
    logic [N-1:0]  cnt_data;
    logic          cnt_updn;
    logic          busy;
    logic          expired;

    always #5 clk = ~clk;

    timer_ctrl #(
        .N  (N),
        .PW (PW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .periodic (periodic),
        .period   (period),
        .presc    (presc),
        .cnt_tic  (cnt_tic),
        .cnt_en   (cnt_en),
        .cnt_load (cnt_load),
        .cnt_data (cnt_data),
        .cnt_updn (cnt_updn),
        .busy     (busy),
        .expired  (expired)
    );

    // Behavioural counter attached to the DUT.
    logic [N-1:0] cnt_q;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)        cnt_q <= '0;
        else if (cnt_en)   cnt_q <= cnt_load ? cnt_data : (cnt_updn ? cnt_q + 1'b1 : cnt_q - 1'b1);
    end
    assign cnt_tic = cnt_en && !cnt_load && !cnt_updn && (cnt_q == N'(1));

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int exp_log[$];

    // Reference model state.
    bit           m_active = 0;
    int           m_load_c = 0;
    int           m_exp_c  = -1;
    int           m_p      = 0;
    int           m_d      = 0;
    bit           m_per    = 0;
    logic [N-1:0] m_data   = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Packed output view: {busy, en, load, expired, updn, data}
    function automatic logic [31:0] dut_out();
        return {19'b0, busy, cnt_en, cnt_load, expired, cnt_updn, cnt_data};
    endfunction

    function automatic logic [31:0] model_out();
        int L, pos;
        logic e, l;
        e = 1'b0;
        l = 1'b0;
        if (m_active) begin
            L   = m_p * (m_d + 1) + 1;
            pos = (cyc - m_load_c) % L;
            l   = (pos == 0);
            e   = ((pos % (m_d + 1)) == 0);
        end
        return {19'b0, m_active, e, l, (cyc == m_exp_c), 1'b0, m_data};
    endfunction

    task automatic model_reset();
        m_active = 0;
        m_exp_c  = -1;
        m_data   = '0;
    endtask

    task automatic model_update();
        int L, pos;
        if (stop) begin
            m_active = 0;
            m_exp_c  = -1;
        end else if (m_active) begin
            L   = m_p * (m_d + 1) + 1;
            pos = (cyc - m_load_c) % L;
            if (pos == L - 1) begin
                m_exp_c = cyc + 1;
                if (!m_per) m_active = 0;
            end
        end else if (start && (period != '0)) begin
            m_active = 1;
            m_load_c = cyc + 1;
            m_p      = int'(period);
            m_d      = int'(presc);
            m_per    = periodic;
            m_data   = period;
        end
    endtask

    // Drive one cycle's inputs and compare against the model.
    task automatic drive_sample(input logic s, input logic sp, input logic pd, input int p, input int d);
        start    = s;
        stop     = sp;
        periodic = pd;
        period   = p[N-1:0];
        presc    = d[PW-1:0];
        #1;
        check("model", dut_out(), model_out());
        if (expired) exp_log.push_back(cyc);
    endtask

    task automatic advance();
        model_update();
        @(negedge clk);
        cyc++;
    endtask

    task automatic tick(input logic s, input logic sp, input logic pd, input int p, input int d);
        drive_sample(s, sp, pd, p, d);
        advance();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0);
    endtask

    task automatic check_log(input string name, input int n_exp, input int first, input int step);
        check({name, "_count"}, exp_log.size(), n_exp);
        for (int i = 0; i < n_exp; i++)
            check({name, "_at"}, (i < exp_log.size()) ? exp_log[i] : -1, first + step * i);
    endtask

    typedef struct {
        logic s;
        logic sp;
        int   p;
        int   d;
        logic [3:0] exp;   // {busy, cnt_en, cnt_load, expired}
    } vec_t;

    vec_t tbl[13];
    int   c0;

    initial begin
        // One-shot P=3 D=1, a P=5 start while busy, then a P=0 start.
        tbl[0]  = '{1, 0, 3, 1, 4'b0000};
        tbl[1]  = '{0, 0, 0, 0, 4'b1110};
        tbl[2]  = '{0, 0, 0, 0, 4'b1000};
        tbl[3]  = '{0, 0, 0, 0, 4'b1100};
        tbl[4]  = '{1, 0, 5, 0, 4'b1000};
        tbl[5]  = '{0, 0, 0, 0, 4'b1100};
        tbl[6]  = '{0, 0, 0, 0, 4'b1000};
        tbl[7]  = '{0, 0, 0, 0, 4'b1100};
        tbl[8]  = '{0, 0, 0, 0, 4'b0001};
        tbl[9]  = '{0, 0, 0, 0, 4'b0000};
        tbl[10] = '{1, 0, 0, 0, 4'b0000};
        tbl[11] = '{0, 0, 0, 0, 4'b0000};
        tbl[12] = '{0, 0, 0, 0, 4'b0000};

        // Reset state.
        #12;
        check("reset_outputs", dut_out(), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven directed run.
        for (int i = 0; i < 13; i++) begin
            drive_sample(tbl[i].s, tbl[i].sp, 1'b0, tbl[i].p, tbl[i].d);
            check("vec", {28'b0, busy, cnt_en, cnt_load, expired}, {28'b0, tbl[i].exp});
            advance();
        end
        check("data_after_ignored_starts", cnt_data, 3);

        // Periodic P=2 D=0, stopped on a final tic.
        exp_log.delete();
        c0 = cyc;
        tick(1, 0, 1, 2, 0);
        idle(11);
        tick(0, 1, 0, 0, 0);
        idle(6);
        check_log("periodic", 3, c0 + 4, 3);

        // stop together with the final strobe/tic of a one-shot.
        exp_log.delete();
        c0 = cyc;
        tick(1, 0, 0, 2, 1);
        idle(4);
        check("final_tic_cycle", cnt_tic, 1'b1);
        tick(0, 1, 0, 0, 0);
        drive_sample(0, 0, 0, 0, 0);
        check("stop_idle", {busy, cnt_en}, 2'b00);
        advance();
        idle(5);
        check("stop_no_expired", exp_log.size(), 0);

        // Shortest interval and longest prescale.
        exp_log.delete();
        c0 = cyc;
        tick(1, 0, 0, 1, 0);
        idle(5);
        check_log("p1_d0", 1, c0 + 3, 0);

        exp_log.delete();
        c0 = cyc;
        tick(1, 0, 0, 1, (1 << PW) - 1);
        idle((1 << PW) + 4);
        check_log("p1_dmax", 1, c0 + (1 << PW) + 2, 0);

        // Asynchronous reset in the middle of a periodic run.
        tick(1, 0, 1, 5, 3);
        idle(6);
        #2 rst_n = 1'b0;
        #1 check("async_reset", dut_out(), 32'h0);
        model_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        exp_log.delete();
        idle(30);
        check("after_reset_no_expired", exp_log.size(), 0);
        exp_log.delete();
        c0 = cyc;
        tick(1, 0, 0, 2, 0);
        idle(6);
        check_log("restart_after_reset", 1, c0 + 4, 0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0,
                 1'($urandom_range(0, 1)), $urandom_range(0, 6), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
